// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO for any DEPTH >= 2 (power of two not required).
// It provides a fill level, almost-full and almost-empty thresholds, sticky
// overflow and underflow flags, and a synchronous flush (clear_i).
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through. In that
// mode r_data_o shows mem[read pointer] combinationally. When the macro is not
// defined, r_data_o is a register that loads on each accepted read.
module sync_fifo #(
    parameter type data_t     = logic [7:0],
    parameter int  DEPTH      = 8,
    parameter int  AFULL_LVL  = DEPTH - 1,
    parameter int  AEMPTY_LVL = 1,
    localparam int LW         = $clog2(DEPTH + 1),
    localparam int PW         = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  data_t         w_data_i,
    input  logic          w_en_i,
    input  logic          r_en_i,
    output data_t         r_data_o,
    output logic          w_full_o,
    output logic          r_empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic [LW-1:0] level_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_LVL);
    localparam logic [LW-1:0] LVL_AEMPT = LW'(AEMPTY_LVL);
    localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    // Advance a pointer by one slot. It wraps from DEPTH-1 to 0, so DEPTH
    // does not have to be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    data_t          mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic [LW-1:0]  level_nxt_s;
    logic           overflow_r;
    logic           underflow_r;
    logic           full_s;
    logic           empty_s;
    logic           w_acc_s;
    logic           r_acc_s;

    // The status flags depend only on the level register. Requests and
    // clear_i have no combinational path to them.
    assign full_s         = (level_r == LVL_FULL);
    assign empty_s        = (level_r == LVL_ZERO);
    assign w_full_o       = full_s;
    assign r_empty_o      = empty_s;
    assign almost_full_o  = (level_r >= LVL_AFULL);
    assign almost_empty_o = (level_r <= LVL_AEMPT);
    assign level_o        = level_r;
    assign overflow_o     = overflow_r;
    assign underflow_o    = underflow_r;

    // Acceptance. clear_i blocks both requests. When the FIFO is full and
    // both requests are present, only the read is accepted. When it is
    // empty, only the write is accepted.
    assign w_acc_s = w_en_i & ~full_s & ~clear_i;
    assign r_acc_s = r_en_i & ~empty_s & ~clear_i;

    // Next fill level. When a write and a read are both accepted, the level
    // does not change.
    always_comb begin
        level_nxt_s = level_r;
        case ({w_acc_s, r_acc_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, level and sticky error flags. clear_i returns these to zero
    // and ignores any request made in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LVL_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LVL_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (w_acc_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (r_acc_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            level_r <= level_nxt_s;
            if (w_en_i && full_s) begin
                overflow_r <= 1'b1;
            end
            if (r_en_i && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Storage array. It has no reset, and a flush leaves the contents as
    // they are.
    always_ff @(posedge clk_i) begin
        if (w_acc_s) begin
            mem_r[wr_ptr_r] <= w_data_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through mode: the head entry is visible whenever the FIFO holds data.
    assign r_data_o = mem_r[rd_ptr_r];
`else
    data_t rd_data_r;

    // Registered read data. It loads on an accepted read and otherwise keeps
    // its value, including across a flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_r <= data_t'(1'b0);
        end else if (r_acc_s) begin
            rd_data_r <= mem_r[rd_ptr_r];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign r_data_o = rd_data_r;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo. Unit 0 has DEPTH=8, AFULL_LVL=6 and
// AEMPTY_LVL=2. Unit 1 has DEPTH=5 and default thresholds. Each unit has a
// queue-based reference model. Both units are checked after every clock.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] w_en;
    logic [1:0] r_en;
    logic [1:0] clr;
    logic [7:0] w_data [2];
    logic [7:0] r_data [2];
    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] afull;
    logic [1:0] aempty;
    logic [1:0] ovf;
    logic [1:0] unf;
    logic [3:0] level0;
    logic [2:0] level1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [1:0] m_ovf;
    logic [1:0] m_unf;
    logic [7:0] m_rdata [2];
    int depth [2] = '{8, 5};
    int afl   [2] = '{6, 4};
    int ael   [2] = '{2, 1};

    always #5 clk = ~clk;

    sync_fifo #(.data_t(logic [7:0]), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(2)) u_fifo8 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[0]), .w_data_i(w_data[0]),
        .w_en_i(w_en[0]), .r_en_i(r_en[0]), .r_data_o(r_data[0]),
        .w_full_o(full[0]), .r_empty_o(empty[0]), .almost_full_o(afull[0]),
        .almost_empty_o(aempty[0]), .level_o(level0),
        .overflow_o(ovf[0]), .underflow_o(unf[0])
    );

    sync_fifo #(.data_t(logic [7:0]), .DEPTH(5)) u_fifo5 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr[1]), .w_data_i(w_data[1]),
        .w_en_i(w_en[1]), .r_en_i(r_en[1]), .r_data_o(r_data[1]),
        .w_full_o(full[1]), .r_empty_o(empty[1]), .almost_full_o(afull[1]),
        .almost_empty_o(aempty[1]), .level_o(level1),
        .overflow_o(ovf[1]), .underflow_o(unf[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_ovf = 2'b00;
        m_unf = 2'b00;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
    endtask

    task automatic check_unit(input int u);
        int lvl;
        logic [7:0] head;
        logic [31:0] dut_lvl;
        if (u == 0) begin
            lvl = q0.size();
            head = (lvl > 0) ? q0[0] : 8'h00;
            dut_lvl = {28'd0, level0};
        end else begin
            lvl = q1.size();
            head = (lvl > 0) ? q1[0] : 8'h00;
            dut_lvl = {29'd0, level1};
        end
        chk($sformatf("u%0d level", u), dut_lvl, lvl);
        chk($sformatf("u%0d full", u), {31'd0, full[u]}, {31'd0, lvl == depth[u]});
        chk($sformatf("u%0d empty", u), {31'd0, empty[u]}, {31'd0, lvl == 0});
        chk($sformatf("u%0d almost_full", u), {31'd0, afull[u]}, {31'd0, lvl >= afl[u]});
        chk($sformatf("u%0d almost_empty", u), {31'd0, aempty[u]}, {31'd0, lvl <= ael[u]});
        chk($sformatf("u%0d overflow", u), {31'd0, ovf[u]}, {31'd0, m_ovf[u]});
        chk($sformatf("u%0d underflow", u), {31'd0, unf[u]}, {31'd0, m_unf[u]});
`ifdef SYNC_FIFO_FWFT_EN
        if (lvl > 0) begin
            chk($sformatf("u%0d head", u), {24'd0, r_data[u]}, {24'd0, head});
        end
`else
        chk($sformatf("u%0d r_data", u), {24'd0, r_data[u]}, {24'd0, m_rdata[u]});
`endif
    endtask

    // One clock on unit u: drive the requests, let the edge happen, update
    // the reference model, then check both units.
    task automatic cyc(input int u, input bit w, input bit r, input logic [7:0] d, input bit c);
        logic [7:0] q [$];
        bit full_m;
        bit empty_m;
        w_en = 2'b00;
        r_en = 2'b00;
        clr  = 2'b00;
        w_en[u] = w;
        r_en[u] = r;
        clr[u]  = c;
        w_data[u] = d;
        @(posedge clk);
        #1;
        if (u == 0) q = q0; else q = q1;
        if (c) begin
            q.delete();
            m_ovf[u] = 1'b0;
            m_unf[u] = 1'b0;
        end else begin
            full_m  = (q.size() == depth[u]);
            empty_m = (q.size() == 0);
            if (w && full_m) m_ovf[u] = 1'b1;
            if (r && empty_m) m_unf[u] = 1'b1;
            if (r && !empty_m) m_rdata[u] = q.pop_front();
            if (w && !full_m) q.push_back(d);
        end
        if (u == 0) q0 = q; else q1 = q;
        w_en = 2'b00;
        r_en = 2'b00;
        clr  = 2'b00;
        check_unit(0);
        check_unit(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        w_en = 2'b00;
        r_en = 2'b00;
        clr = 2'b00;
        w_data[0] = 8'h00;
        w_data[1] = 8'h00;
        model_reset();
        #2;
        check_unit(0);
        check_unit(1);
        #5 rst = 1'b0;

        // Fill the 8-deep FIFO with 0x01..0x08. Each cycle also checks the
        // threshold flags at every level.
        for (int i = 1; i <= 8; i++) cyc(0, 1'b1, 1'b0, 8'(i), 1'b0);
        chk("full_after_8", {31'd0, full[0]}, 32'd1);
        chk("level_after_8", {28'd0, level0}, 32'd8);

        // Write and read while full: the head is read, 0xAA is dropped, and
        // overflow sets.
        cyc(0, 1'b1, 1'b1, 8'hAA, 1'b0);
        chk("ovf_level", {28'd0, level0}, 32'd7);
        chk("ovf_data", {24'd0, r_data[0]}, 32'h01);

        // Drain the remaining entries. Overflow stays set.
        for (int i = 0; i < 7; i++) cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("ovf_sticky", {31'd0, ovf[0]}, 32'd1);

        // Write and read while empty: the write lands, and underflow sets.
        cyc(0, 1'b1, 1'b1, 8'h55, 1'b0);
        chk("unf_level", {28'd0, level0}, 32'd1);
        cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Flush with a write pending at level 4.
        for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
        cyc(0, 1'b1, 1'b0, 8'h77, 1'b1);
        chk("clear_level", {28'd0, level0}, 32'd0);

        // Flush with a write pending while full must not set overflow.
        for (int i = 0; i < 8; i++) cyc(0, 1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
        cyc(0, 1'b1, 1'b0, 8'hEE, 1'b1);
        chk("clear_no_ovf", {31'd0, ovf[0]}, 32'd0);

        // Wrap-around on the 5-deep FIFO, with single read/write pairs
        // between the fill and the drain.
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 5; k++) cyc(1, 1'b1, 1'b0, 8'(c * 16 + k), 1'b0);
            cyc(1, 1'b0, 1'b1, 8'h00, 1'b0);
            cyc(1, 1'b1, 1'b0, 8'(c * 16 + 8), 1'b0);
            for (int k = 0; k < 5; k++) cyc(1, 1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Random traffic in phases that lean toward writes, then reads, so
        // both the full and empty boundaries are reached.
        for (int n = 0; n < 600; n++) begin
            int u;
            bit wr;
            bit rd;
            bit cl;
            u  = int'($urandom_range(0, 1));
            if (((n / 40) % 2) == 0) begin
                wr = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 3) == 0);
            end else begin
                wr = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            cl = ($urandom_range(0, 47) == 0);
            cyc(u, wr, rd, 8'($urandom), cl);
        end

        // Assert reset during a burst and check the outputs before the next edge.
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 8'h90 + 8'(i), 1'b0);
        w_en[0] = 1'b1;
        w_data[0] = 8'h3C;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_unit(0);
        check_unit(1);
        @(posedge clk);
        #1;
        w_en = 2'b00;
        rst = 1'b0;
        cyc(0, 1'b1, 1'b0, 8'h11, 1'b0);
        cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_reset_data", {24'd0, r_data[0]}, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
